pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum data-memory wait cycles before abort, range 2..255.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 id_rs1_addr_i, id_rs2_addr_i  in  5 each  source registers of the instruction in ID.
REQ-005 id_rs1_used_i, id_rs2_used_i  in  1 each  the corresponding source is actually read.
REQ-006 ex_rd_addr_i  in  5; ex_is_load_i  in  1; ex_rd_wren_i  in  1  destination info of the instruction in EX.
REQ-007 ex_mispredict_i  in  1  EX resolved a branch or jump against the always-taken prediction.
REQ-008 mem_req_i  in  1  MEM stage holds a load or store; mem_ack_i  in  1  data memory completes it this cycle.
REQ-009 pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  pipeline register enables.
REQ-010 if_id_flush_o, id_ex_flush_o, ex_mem_flush_o  out  1 each  synchronous bubble insert (register clears on next edge).
REQ-011 mem_err_o  out  1  one-cycle pulse on memory timeout.
REQ-012 stall_cnt_o, flush_cnt_o  out  32 each  performance counters.

Function
REQ-013 FSM states RUN and MWAIT; enables and flushes are combinational in state and inputs; state, wait counter and performance counters are registered.
REQ-014 Default in RUN, no event: all enables 1, all flushes 0.
REQ-015 Memory freeze: in RUN with mem_req_i=1 and mem_ack_i=0, all five enables 0 and all flushes 0 that same cycle; next state MWAIT; wait_cnt loads 1.
REQ-016 In MWAIT with mem_ack_i=0 and wait_cnt < MEM_TIMEOUT-1, outputs frozen as in REQ-015 and wait_cnt increments.
REQ-017 In MWAIT with mem_ack_i=1, outputs follow the RUN rules (REQ-014, REQ-018..REQ-020) for that cycle; next state RUN.
REQ-018 Timeout: in MWAIT with mem_ack_i=0 and wait_cnt = MEM_TIMEOUT-1, mem_err_o=1, ex_mem_flush_o=1, other enables 1; next state RUN.
REQ-019 Mispredict (not frozen): pc_en_o=1 for redirect, if_id_flush_o=1, id_ex_flush_o=1, all enables 1.
REQ-020 Load-use hazard = ex_is_load_i & ex_rd_wren_i & ex_rd_addr_i≠0 & ((id_rs1_used_i & rs1 match) | (id_rs2_used_i & rs2 match)); response: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, others 1.
REQ-021 Priority: freeze > timeout > mispredict > load-use; a mispredict during freeze is ignored, held by the frozen EX stage, and acted on in the release cycle.
REQ-022 stall_cnt_o increments once per cycle with pc_en_o=0; flush_cnt_o increments once per cycle with if_id_flush_o or id_ex_flush_o asserted; both saturate at 32'hFFFF_FFFF.

Reset
REQ-023 While rst_i=1: state RUN, wait_cnt 0, counters 0, mem_err_o 0, all enables 0, all flushes 1.
REQ-024 Reset during MWAIT abandons the wait; first cycle after reset release follows RUN rules.

Structure
REQ-025 Package pipe_ctrl_pkg holds the state enum (RUN, MWAIT) and the counter width constant.
REQ-026 Sub-module hazard_detect implements the combinational load-use compare of REQ-020.
REQ-027 No other sub-modules; total RTL 120-400 lines.

Verification
REQ-028 EX lw x5, ID add x6,x5,x7 with rs1_used=1 -> one cycle pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; stall_cnt_o=1.
REQ-029 EX load with rd=x0, ID reads x0 -> no stall, all enables 1.
REQ-030 mem_req_i=1, mem_ack_i low 3 cycles then high -> 3 frozen cycles, release on ack cycle, stall_cnt_o=4.
REQ-031 MEM_TIMEOUT=4, mem_ack_i never asserted -> freeze 3 cycles, mem_err_o pulse on 4th with ex_mem_flush_o=1, then RUN.
REQ-032 ex_mispredict_i=1 with simultaneous load-use hazard -> flush (REQ-019) wins, pc_en_o=1, flush_cnt_o=1.
REQ-033 rst_i=1 mid-MWAIT -> next cycle enables 0, flushes 1, counters 0; after release normal RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and widths for the pipeline controller
package pipe_ctrl_pkg;
    typedef enum logic {RUN, MWAIT} state_e;
    localparam int CNT_W  = 32;
    localparam int WAIT_W = 8;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs and stage enables/flushes between pipeline and controller
interface pipe_ctrl_if;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
    logic        id_rs1_used_i, id_rs2_used_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_is_load_i, ex_rd_wren_i, ex_mispredict_i;
    logic        mem_req_i, mem_ack_i;
    logic        pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
    logic        if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
    logic        mem_err_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;
    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               ex_rd_addr_i, ex_is_load_i, ex_rd_wren_i, ex_mispredict_i, mem_req_i, mem_ack_i,
        input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
               if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_err_o, stall_cnt_o, flush_cnt_o
    );
    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               ex_rd_addr_i, ex_is_load_i, ex_rd_wren_i, ex_mispredict_i, mem_req_i, mem_ack_i,
        output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
               if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_err_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: load-use compare between the load in EX and the sources read in ID
module hazard_detect (
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    input  logic [4:0] rd_addr_i,
    input  logic       is_load_i,
    input  logic       rd_wren_i,
    output logic       hazard_o
);
    assign hazard_o = is_load_i & rd_wren_i & (rd_addr_i != 5'd0) &
                      ((rs1_used_i & (rs1_addr_i == rd_addr_i)) | (rs2_used_i & (rs2_addr_i == rd_addr_i)));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/freeze control for a 5-stage pipeline with data-memory timeout
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input logic        clk_i,
    input logic        rst_i,
    pipe_ctrl_if.slave p
);
    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic               hazard, in_wait, timeout, freeze, mispred, load_use;
    logic [4:0]         en;
    logic [2:0]         fl;

    hazard_detect u_hazard (
        .rs1_addr_i (p.id_rs1_addr_i),
        .rs2_addr_i (p.id_rs2_addr_i),
        .rs1_used_i (p.id_rs1_used_i),
        .rs2_used_i (p.id_rs2_used_i),
        .rd_addr_i  (p.ex_rd_addr_i),
        .is_load_i  (p.ex_is_load_i),
        .rd_wren_i  (p.ex_rd_wren_i),
        .hazard_o   (hazard)
    );

    // A mispredict arriving while frozen stays in the held EX stage and is seen on release
    always_comb begin
        in_wait     = state_q == MWAIT;
        timeout     = in_wait & ~p.mem_ack_i & (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
        freeze      = ~p.mem_ack_i & (in_wait ? ~timeout : p.mem_req_i);
        mispred     = ~freeze & ~timeout & p.ex_mispredict_i;
        load_use    = ~freeze & ~timeout & ~p.ex_mispredict_i & hazard;
        en          = rst_i ? 5'b00000 : {{2{~freeze & ~load_use}}, {3{~freeze}}};
        fl          = rst_i ? 3'b111 : {mispred, mispred | load_use, timeout};
        state_d     = freeze ? MWAIT : RUN;
        wait_cnt_d  = freeze ? (in_wait ? wait_cnt_q + WAIT_W'(1) : WAIT_W'(1)) : '0;
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, ~en[4] & ~&stall_cnt_q};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, (fl[2] | fl[1]) & ~&flush_cnt_q};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign {p.pc_en_o, p.if_id_en_o, p.id_ex_en_o, p.ex_mem_en_o, p.mem_wb_en_o} = en;
    assign {p.if_id_flush_o, p.id_ex_flush_o, p.ex_mem_flush_o} = fl;
    assign p.mem_err_o   = ~rst_i & timeout;
    assign p.stall_cnt_o = stall_cnt_q;
    assign p.flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus random traffic against a cycle-level reference model
module tb_pipe_ctrl;
    localparam int T = 4;
    logic clk = 0, rst = 1;
    int total = 0, bad = 0;
    int waited = 0;
    logic [31:0] m_stall = 0, m_flush = 0;

    pipe_ctrl_if b();
    pipe_ctrl #(.MEM_TIMEOUT(T)) dut (.clk_i(clk), .rst_i(rst), .p(b.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set(input bit ld, input bit wr, input int rd, input int r1, input bit u1,
                       input int r2, input bit u2, input bit mp, input bit req, input bit ack);
        b.ex_is_load_i = ld; b.ex_rd_wren_i = wr; b.ex_rd_addr_i = 5'(rd);
        b.id_rs1_addr_i = 5'(r1); b.id_rs1_used_i = u1;
        b.id_rs2_addr_i = 5'(r2); b.id_rs2_used_i = u2;
        b.ex_mispredict_i = mp; b.mem_req_i = req; b.mem_ack_i = ack;
    endtask

    // Expected behaviour derived from the priority rules, one call per clock cycle
    task automatic tick();
        logic [4:0] en;
        logic [2:0] fl;
        logic err;
        bit hz, to, frz;
        #1;
        hz  = b.ex_is_load_i && b.ex_rd_wren_i && b.ex_rd_addr_i != 0 &&
              ((b.id_rs1_used_i && b.id_rs1_addr_i == b.ex_rd_addr_i) ||
               (b.id_rs2_used_i && b.id_rs2_addr_i == b.ex_rd_addr_i));
        to  = !rst && waited > 0 && !b.mem_ack_i && waited == T - 1;
        frz = !rst && !to && !b.mem_ack_i && (waited > 0 || b.mem_req_i);
        err = 0;
        if (rst)                  begin en = 5'b00000; fl = 3'b111; end
        else if (frz)             begin en = 5'b00000; fl = 3'b000; end
        else if (to)              begin en = 5'b11111; fl = 3'b001; err = 1; end
        else if (b.ex_mispredict_i) begin en = 5'b11111; fl = 3'b110; end
        else if (hz)              begin en = 5'b00111; fl = 3'b010; end
        else                      begin en = 5'b11111; fl = 3'b000; end
        chk("enables", {27'd0, b.pc_en_o, b.if_id_en_o, b.id_ex_en_o, b.ex_mem_en_o, b.mem_wb_en_o}, {27'd0, en});
        chk("flushes", {29'd0, b.if_id_flush_o, b.id_ex_flush_o, b.ex_mem_flush_o}, {29'd0, fl});
        chk("mem_err", {31'd0, b.mem_err_o}, {31'd0, err});
        chk("stall_cnt", b.stall_cnt_o, m_stall);
        chk("flush_cnt", b.flush_cnt_o, m_flush);
        if (rst) begin
            waited = 0; m_stall = 0; m_flush = 0;
        end else begin
            waited = frz ? waited + 1 : 0;
            if (!en[4] && m_stall != 32'hFFFF_FFFF) m_stall++;
            if ((fl[2] || fl[1]) && m_flush != 32'hFFFF_FFFF) m_flush++;
        end
        @(negedge clk);
    endtask

    initial begin
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        tick(); tick();
        rst = 0;
        set(1, 1, 5, 5, 1, 7, 1, 0, 0, 0); tick();
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("loaduse_stall_cnt", b.stall_cnt_o, 32'd1);
        set(1, 1, 0, 0, 1, 0, 1, 0, 0, 0); tick();
        set(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); tick(); tick();
        set(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("memwait_stall_cnt", b.stall_cnt_o, 32'd4);
        set(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); tick(); tick(); tick(); tick();
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        rst = 1; tick();
        rst = 0;
        set(1, 1, 3, 3, 1, 0, 0, 1, 0, 0); tick();
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("mispredict_flush_cnt", b.flush_cnt_o, 32'd1);
        set(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); tick();
        rst = 1; set(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); tick();
        rst = 0; set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(99) == 0;
            set($urandom_range(1), $urandom_range(3) != 0, $urandom_range(3),
                $urandom_range(3), $urandom_range(1), $urandom_range(3), $urandom_range(1),
                $urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
